// File: rtl/hood_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hood_pkg
//  Description : Shared encodings for the range-hood mode sequencer.
//                Contains the mode codes, the state_code constants that the
//                work-time block also decodes, and per-mode decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package hood_pkg;

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_STBY  = 3'd1,
        MODE_MENU  = 3'd2,
        MODE_L1    = 3'd3,
        MODE_L2    = 3'd4,
        MODE_L3    = 3'd5,
        MODE_COOL  = 3'd6,
        MODE_CLEAN = 3'd7
    } mode_t;

    localparam logic [1:0] SC_IDLE  = 2'b00;
    localparam logic [1:0] SC_MENU  = 2'b01;
    localparam logic [1:0] SC_RUN   = 2'b10;
    localparam logic [1:0] SC_CLEAN = 2'b11;

    // state_code presented to the work-time block for a given mode
    function automatic logic [1:0] state_code_of(input mode_t m);
        case (m)
            MODE_MENU:                         state_code_of = SC_MENU;
            MODE_L1, MODE_L2, MODE_L3,
            MODE_COOL:                         state_code_of = SC_RUN;
            MODE_CLEAN:                        state_code_of = SC_CLEAN;
            default:                           state_code_of = SC_IDLE;
        endcase
    endfunction

    // motor speed for a given mode; cooldown runs at level 2, self-clean at 3
    function automatic logic [1:0] fan_level_of(input mode_t m);
        case (m)
            MODE_L1:                 fan_level_of = 2'd1;
            MODE_L2, MODE_COOL:      fan_level_of = 2'd2;
            MODE_L3, MODE_CLEAN:     fan_level_of = 2'd3;
            default:                 fan_level_of = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : sec_countdown
//  Description : Tick prescaler plus loadable seconds down-counter.
//                Ports: clk, reset (sync, active-high), clear (zero count and
//                prescaler), load/load_val (start a countdown, prescaler
//                cleared), tick (100 Hz strobe); count (seconds remaining),
//                expire (combinational: the current edge ends the countdown).
//  Revision    : 1.0  initial release
// ============================================================================
module sec_countdown #(
    parameter int TICKS_PER_SEC = 100,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    localparam int               c_PS_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0]  c_ONE    = CNT_W'(1);

    logic [c_PS_W-1:0] r_presc;
    logic [CNT_W-1:0]  r_count;
    logic              w_sec_strobe;

    // the prescaler only advances while a countdown is running, so it reads
    // as zero in every state that has no countdown
    assign w_sec_strobe = tick && (r_presc == c_PS_MAX) && (r_count != '0);
    assign expire       = w_sec_strobe && (r_count == c_ONE);
    assign count        = r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (load) begin
            r_presc <= '0;
            r_count <= load_val;
        end else if (r_count == '0) begin
            r_presc <= '0;
        end else if (tick) begin
            if (w_sec_strobe) begin
                r_presc <= '0;
                r_count <= r_count - c_ONE;
            end else begin
                r_presc <= r_presc + c_PS_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hood_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hood_mode_ctrl
//  Description : Range-hood operating-mode sequencer. Turns debounced button
//                pulses into the mode FSM and owns the hurricane, cooldown
//                and self-clean timers.
//                Inputs : clk, reset, tick_100hz, power_on, btn_menu, btn_l1,
//                         btn_l2, btn_l3, btn_clean
//                Outputs: mode, state_code, fan_level, countdown, hurr_used,
//                         clean_done (all registered)
//  Revision    : 1.0  initial release
// ============================================================================
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int HURR_SEC      = 60,
    parameter int COOL_SEC      = 60,
    parameter int CLEAN_SEC     = 180,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_100hz,
    input  logic             power_on,
    input  logic             btn_menu,
    input  logic             btn_l1,
    input  logic             btn_l2,
    input  logic             btn_l3,
    input  logic             btn_clean,
    output logic [2:0]       mode,
    output logic [1:0]       state_code,
    output logic [1:0]       fan_level,
    output logic [CNT_W-1:0] countdown,
    output logic             hurr_used,
    output logic             clean_done
);

    mode_t            r_mode;
    mode_t            w_mode_nxt;
    logic [1:0]       r_state_code;
    logic [1:0]       r_fan_level;
    logic             r_hurr_used;
    logic             r_clean_done;

    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_clear;
    logic             w_hurr_set;
    logic             w_clean_pulse;
    logic             w_expire;

    sec_countdown #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .CNT_W         (CNT_W)
    ) u_sec_countdown (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (tick_100hz),
        .count    (countdown),
        .expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode       <= MODE_OFF;
            r_state_code <= SC_IDLE;
            r_fan_level  <= 2'd0;
            r_hurr_used  <= 1'b0;
            r_clean_done <= 1'b0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_state_code <= state_code_of(w_mode_nxt);
            r_fan_level  <= fan_level_of(w_mode_nxt);
            r_clean_done <= w_clean_pulse;
            if (w_clear)
                r_hurr_used <= 1'b0;
            else if (w_hurr_set)
                r_hurr_used <= 1'b1;
        end
    end

    // Button priority is menu > clean > l3 > l2 > l1; a winner that the
    // current mode ignores still swallows the lower buttons of that clock.
    always_comb begin
        w_mode_nxt    = r_mode;
        w_load        = 1'b0;
        w_load_val    = '0;
        w_clear       = 1'b0;
        w_hurr_set    = 1'b0;
        w_clean_pulse = 1'b0;
        if (!power_on) begin
            w_mode_nxt = MODE_OFF;
            w_clear    = 1'b1;
        end else begin
            case (r_mode)
                MODE_OFF:  w_mode_nxt = MODE_STBY;
                MODE_STBY: if (btn_menu) w_mode_nxt = MODE_MENU;
                MODE_MENU: begin
                    if (btn_menu) begin
                        w_mode_nxt = MODE_STBY;
                    end else if (btn_clean) begin
                        w_mode_nxt = MODE_CLEAN;
                        w_load     = 1'b1;
                        w_load_val = CNT_W'(CLEAN_SEC);
                    end else if (btn_l3) begin
                        if (!r_hurr_used) begin
                            w_mode_nxt = MODE_L3;
                            w_load     = 1'b1;
                            w_load_val = CNT_W'(HURR_SEC);
                            w_hurr_set = 1'b1;
                        end
                    end else if (btn_l2) begin
                        w_mode_nxt = MODE_L2;
                    end else if (btn_l1) begin
                        w_mode_nxt = MODE_L1;
                    end
                end
                MODE_L1, MODE_L2: begin
                    if (btn_menu)
                        w_mode_nxt = MODE_STBY;
                    else if (btn_clean || btn_l3)
                        w_mode_nxt = r_mode;
                    else if (btn_l2)
                        w_mode_nxt = MODE_L2;
                    else if (btn_l1)
                        w_mode_nxt = MODE_L1;
                end
                MODE_L3: begin
                    // menu beats a same-clock expiry; the load overrides the decrement
                    if (btn_menu) begin
                        w_mode_nxt = MODE_COOL;
                        w_load     = 1'b1;
                        w_load_val = CNT_W'(COOL_SEC);
                    end else if (w_expire) begin
                        w_mode_nxt = MODE_L2;
                    end
                end
                MODE_COOL: if (w_expire) w_mode_nxt = MODE_STBY;
                MODE_CLEAN: begin
                    if (w_expire) begin
                        w_mode_nxt    = MODE_STBY;
                        w_clean_pulse = 1'b1;
                    end
                end
                default: w_mode_nxt = MODE_OFF;
            endcase
        end
    end

    assign mode       = r_mode;
    assign state_code = r_state_code;
    assign fan_level  = r_fan_level;
    assign hurr_used  = r_hurr_used;
    assign clean_done = r_clean_done;

endmodule
`default_nettype wire

// File: tb/tb_hood_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hood_mode_ctrl
//  Description : Directed self-checking bench for hood_mode_ctrl using short
//                timer parameters (2 ticks/s, L3 3 s, cool 2 s, clean 4 s).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hood_mode_ctrl;
    import hood_pkg::*;

    localparam int c_CNT_W = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               tick_100hz = 1'b0;
    logic               power_on = 1'b0;
    logic               btn_menu = 1'b0;
    logic               btn_l1 = 1'b0;
    logic               btn_l2 = 1'b0;
    logic               btn_l3 = 1'b0;
    logic               btn_clean = 1'b0;
    logic [2:0]         mode;
    logic [1:0]         state_code;
    logic [1:0]         fan_level;
    logic [c_CNT_W-1:0] countdown;
    logic               hurr_used;
    logic               clean_done;

    int n_cmp = 0;
    int n_err = 0;

    hood_mode_ctrl #(
        .TICKS_PER_SEC (2),
        .HURR_SEC      (3),
        .COOL_SEC      (2),
        .CLEAN_SEC     (4),
        .CNT_W         (c_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_100hz (tick_100hz),
        .power_on   (power_on),
        .btn_menu   (btn_menu),
        .btn_l1     (btn_l1),
        .btn_l2     (btn_l2),
        .btn_l3     (btn_l3),
        .btn_clean  (btn_clean),
        .mode       (mode),
        .state_code (state_code),
        .fan_level  (fan_level),
        .countdown  (countdown),
        .hurr_used  (hurr_used),
        .clean_done (clean_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // full observable state in one call
    task automatic chk_all(input string tag, input mode_t m, input logic [1:0] sc,
                           input logic [1:0] fl, input int cd, input logic hu, input logic cdn);
        chk({tag, ".mode"},       32'(mode),       32'(m));
        chk({tag, ".state_code"}, 32'(state_code), 32'(sc));
        chk({tag, ".fan_level"},  32'(fan_level),  32'(fl));
        chk({tag, ".countdown"},  32'(countdown),  32'(cd));
        chk({tag, ".hurr_used"},  32'(hurr_used),  32'(hu));
        chk({tag, ".clean_done"}, 32'(clean_done), 32'(cdn));
    endtask

    // one clock; outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // buttons: {menu, clean, l3, l2, l1} for exactly one clock
    task automatic press(input logic [4:0] b);
        {btn_menu, btn_clean, btn_l3, btn_l2, btn_l1} = b;
        cyc();
        {btn_menu, btn_clean, btn_l3, btn_l2, btn_l1} = 5'b0;
    endtask

    task automatic ticks(input int n);
        tick_100hz = 1'b1;
        repeat (n) cyc();
        tick_100hz = 1'b0;
    endtask

    localparam logic [4:0] B_MENU  = 5'b10000;
    localparam logic [4:0] B_CLEAN = 5'b01000;
    localparam logic [4:0] B_L3    = 5'b00100;
    localparam logic [4:0] B_L2    = 5'b00010;
    localparam logic [4:0] B_L1    = 5'b00001;

    initial begin
        // reset state
        repeat (3) cyc();
        chk_all("reset", MODE_OFF, 2'b00, 2'd0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc();
        chk("off_hold.mode", 32'(mode), 32'(MODE_OFF));
        power_on = 1'b1;
        cyc();
        chk_all("stby", MODE_STBY, 2'b00, 2'd0, 0, 1'b0, 1'b0);

        // 1: hurricane run and expiry to L2
        press(B_MENU);
        chk_all("menu", MODE_MENU, 2'b01, 2'd0, 0, 1'b0, 1'b0);
        press(B_L3);
        chk_all("l3_enter", MODE_L3, 2'b10, 2'd3, 3, 1'b1, 1'b0);
        ticks(5);
        chk_all("l3_5ticks", MODE_L3, 2'b10, 2'd3, 1, 1'b1, 1'b0);
        ticks(1);
        chk_all("l3_expire", MODE_L2, 2'b10, 2'd2, 0, 1'b1, 1'b0);

        // 2: one-shot hurricane, re-armed by power cycle
        press(B_MENU);
        chk("l2_menu.mode", 32'(mode), 32'(MODE_STBY));
        press(B_MENU);
        press(B_L3);
        chk("l3_used.mode", 32'(mode), 32'(MODE_MENU));
        press(B_L2);
        chk_all("menu_l2", MODE_L2, 2'b10, 2'd2, 0, 1'b1, 1'b0);
        power_on = 1'b0;
        cyc();
        chk_all("pwr_off", MODE_OFF, 2'b00, 2'd0, 0, 1'b0, 1'b0);
        power_on = 1'b1;
        cyc();
        press(B_MENU);
        press(B_L3);
        chk_all("l3_rearm", MODE_L3, 2'b10, 2'd3, 3, 1'b1, 1'b0);

        // 3: leave L3 through cooldown
        ticks(1);
        press(B_MENU);
        chk_all("cool", MODE_COOL, 2'b10, 2'd2, 2, 1'b1, 1'b0);
        press(B_L1);
        chk("cool_ign.mode", 32'(mode), 32'(MODE_COOL));
        ticks(3);
        chk("cool_3t.countdown", 32'(countdown), 32'd1);
        ticks(1);
        chk_all("cool_done", MODE_STBY, 2'b00, 2'd0, 0, 1'b1, 1'b0);

        // 4: self-clean
        press(B_MENU);
        press(B_CLEAN);
        chk_all("clean", MODE_CLEAN, 2'b11, 2'd3, 4, 1'b1, 1'b0);
        press(B_MENU);
        press(B_L1);
        chk("clean_ign.mode", 32'(mode), 32'(MODE_CLEAN));
        ticks(7);
        chk_all("clean_7t", MODE_CLEAN, 2'b11, 2'd3, 1, 1'b1, 1'b0);
        ticks(1);
        chk_all("clean_done", MODE_STBY, 2'b00, 2'd0, 0, 1'b1, 1'b1);
        cyc();
        chk("clean_pulse_end", 32'(clean_done), 32'd0);

        // 5: simultaneous buttons and menu racing L3 expiry
        press(B_MENU);
        press(B_MENU | B_L2 | B_L1);
        chk("menu_wins.mode", 32'(mode), 32'(MODE_STBY));
        press(B_MENU);
        press(B_L3 | B_L2);
        chk("l3_blocks_l2.mode", 32'(mode), 32'(MODE_MENU));
        press(B_L1);
        chk_all("l1", MODE_L1, 2'b10, 2'd1, 0, 1'b1, 1'b0);
        press(B_CLEAN | B_L2);
        chk("l1_clean_blocks.mode", 32'(mode), 32'(MODE_L1));
        press(B_L2);
        chk("l1_to_l2.mode", 32'(mode), 32'(MODE_L2));
        power_on = 1'b0;
        cyc();
        power_on = 1'b1;
        cyc();
        press(B_MENU);
        press(B_L3);
        ticks(5);
        chk("race_pre.countdown", 32'(countdown), 32'd1);
        tick_100hz = 1'b1;
        press(B_MENU);
        tick_100hz = 1'b0;
        chk_all("race_cool", MODE_COOL, 2'b10, 2'd2, 2, 1'b1, 1'b0);
        ticks(4);
        chk("race_stby.mode", 32'(mode), 32'(MODE_STBY));

        // 6: reset mid-clean
        press(B_MENU);
        press(B_CLEAN);
        ticks(3);
        reset = 1'b1;
        cyc();
        chk_all("rst_mid", MODE_OFF, 2'b00, 2'd0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc();
        chk_all("rst_after", MODE_STBY, 2'b00, 2'd0, 0, 1'b0, 1'b0);
        ticks(8);
        chk("rst_no_done.clean_done", 32'(clean_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // absolute bound so the run cannot hang
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
